// File: rtl/rram_pkg.sv
// rram_pkg
// Shared definitions for the RRAM array emulator: line drive codes
// (pair {IN0,IN1}), the controller state enum, counter width and the
// saturating 3-bit helper used by the per-column MAC popcount.
package rram_pkg;

    localparam logic [1:0] WL_DRV   = 2'b01;  // word line write / MAC drive
    localparam logic [1:0] WL_RD    = 2'b00;  // word line read select
    localparam logic [1:0] LINE_GND = 2'b11;
    localparam logic [1:0] BL_SET   = 2'b00;
    localparam logic [1:0] BL_PRE   = 2'b01;
    localparam logic [1:0] SL_RST   = 2'b01;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE    = 2'd1,
        ST_READ_PRE = 2'd2,
        ST_MAC_CONV = 2'd3
    } state_t;

    function automatic logic [2:0] sat3(input int n);
        return (n > 7) ? 3'd7 : n[2:0];
    endfunction

endpackage

// File: rtl/rram_array_emulator_if.sv
// rram_array_emulator_if
// Line-driver / sense / ADC bundle of the RRAM array emulator.
//   master : drives enables, precharge, sense/ADC enables and line codes
//   slave  : returns CSA row data, 3-bit MAC codes, ADC_VALID and ERR_FLAG
interface rram_array_emulator_if #(
    parameter int ARRAY_SIZE = 16
);
    logic                  ENABLE_WL;
    logic                  ENABLE_SL;
    logic                  ENABLE_BL;
    logic                  PRE;
    logic                  SAEN_CSA;
    logic [1:0]            CLK_EN_ADC;
    logic [ARRAY_SIZE-1:0] IN0_WL;
    logic [ARRAY_SIZE-1:0] IN1_WL;
    logic [ARRAY_SIZE-1:0] IN0_BL;
    logic [ARRAY_SIZE-1:0] IN1_BL;
    logic [ARRAY_SIZE-1:0] IN0_SL;
    logic [ARRAY_SIZE-1:0] IN1_SL;
    logic [ARRAY_SIZE-1:0] CSA;
    logic [ARRAY_SIZE-1:0] ADC_OUT0;
    logic [ARRAY_SIZE-1:0] ADC_OUT1;
    logic [ARRAY_SIZE-1:0] ADC_OUT2;
    logic                  ADC_VALID;
    logic                  ERR_FLAG;

    modport master (
        output ENABLE_WL, ENABLE_SL, ENABLE_BL, PRE, SAEN_CSA, CLK_EN_ADC,
        output IN0_WL, IN1_WL, IN0_BL, IN1_BL, IN0_SL, IN1_SL,
        input  CSA, ADC_OUT0, ADC_OUT1, ADC_OUT2, ADC_VALID, ERR_FLAG
    );

    modport slave (
        input  ENABLE_WL, ENABLE_SL, ENABLE_BL, PRE, SAEN_CSA, CLK_EN_ADC,
        input  IN0_WL, IN1_WL, IN0_BL, IN1_BL, IN0_SL, IN1_SL,
        output CSA, ADC_OUT0, ADC_OUT1, ADC_OUT2, ADC_VALID, ERR_FLAG
    );

endinterface

// File: rtl/rram_col_popcount.sv
// rram_col_popcount
// Counts the active cells of one column and saturates the result to 3 bits.
//   i_bits  : column cells already masked by the active-row mask
//   o_count : min(popcount(i_bits), 7)
module rram_col_popcount
    import rram_pkg::*;
#(
    parameter int ARRAY_SIZE = 16
) (
    input  logic [ARRAY_SIZE-1:0] i_bits,
    output logic [2:0]            o_count
);

    always_comb begin
        o_count = sat3($countones(i_bits));
    end

endmodule

// File: rtl/rram_array_emulator.sv
// rram_array_emulator
// Behavioural RRAM crossbar: ARRAY_SIZE x ARRAY_SIZE binary cells that are
// written with held SET/RESET pulses, read row-wise through the sense amp and
// summed column-wise (in-memory MAC) through a 3-bit ADC.
//   clk : single clock, all state on rising edge
//   rst : asynchronous active-low reset
//   bus : rram_array_emulator_if slave (line codes in, CSA/ADC/ERR out)
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | waiting for a write, read-precharge or MAC request
// ST_WRITE    | write pattern held; counting pulse cycles toward commit
// ST_READ_PRE | bit lines precharged, read rows latched, waiting for sense
// ST_MAC_CONV | active rows latched, ADC latency counting down
module rram_array_emulator
    import rram_pkg::*;
#(
    parameter int ARRAY_SIZE         = 16,
    parameter int WRITE_PULSE_CYCLES = 2,
    parameter int ADC_LATENCY        = 2
) (
    input logic                 clk,
    input logic                 rst,
    rram_array_emulator_if.slave bus
);

    localparam int IDX_W = $clog2(ARRAY_SIZE);
    localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WRITE_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAC_LOAD = CNT_W'(ADC_LATENCY - 1);

    state_t                                r_state;
    logic [CNT_W-1:0]                      r_cnt;
    logic [ARRAY_SIZE-1:0][ARRAY_SIZE-1:0] r_cell;   // [row][col]
    logic [ARRAY_SIZE-1:0]                 r_mask;   // read rows or MAC rows
    logic [IDX_W-1:0]                      r_row;
    logic [IDX_W-1:0]                      r_col;
    logic                                  r_pol;    // 1 = SET, 0 = RESET
    logic [ARRAY_SIZE-1:0]                 r_csa;
    logic [ARRAY_SIZE-1:0]                 r_adc0;
    logic [ARRAY_SIZE-1:0]                 r_adc1;
    logic [ARRAY_SIZE-1:0]                 r_adc2;
    logic                                  r_valid;
    logic                                  r_err;

    logic [ARRAY_SIZE-1:0] w_wl_drv;
    logic [ARRAY_SIZE-1:0] w_wl_rd;
    logic [ARRAY_SIZE-1:0] w_bl_pre;
    logic [ARRAY_SIZE-1:0] w_col_set;
    logic [ARRAY_SIZE-1:0] w_col_rst;
    logic [ARRAY_SIZE-1:0] w_col_gnd;
    logic [ARRAY_SIZE-1:0] w_col_sel;
    logic [ARRAY_SIZE-1:0] w_rd_or;
    logic [ARRAY_SIZE-1:0] w_adc0;
    logic [ARRAY_SIZE-1:0] w_adc1;
    logic [ARRAY_SIZE-1:0] w_adc2;
    logic [IDX_W-1:0]      w_row;
    logic [IDX_W-1:0]      w_col;
    logic                  w_pol;
    logic                  w_wr_frame;
    logic                  w_wr_ok;
    logic                  w_wr_bad;
    logic                  w_wr_same;
    logic                  w_rd_start;
    logic                  w_sense;
    logic                  w_mac_start;
    logic                  w_rd_multi;

    // Per-line decode; codes outside the named set behave as ground.
    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_line
        logic [1:0] w_wl;
        logic [1:0] w_bl;
        logic [1:0] w_sl;
        logic       w_bl_gnd;
        logic       w_sl_gnd;
        assign w_wl      = {bus.IN0_WL[i], bus.IN1_WL[i]};
        assign w_bl      = {bus.IN0_BL[i], bus.IN1_BL[i]};
        assign w_sl      = {bus.IN0_SL[i], bus.IN1_SL[i]};
        assign w_bl_gnd  = (w_bl != BL_SET) && (w_bl != BL_PRE);
        assign w_sl_gnd  = (w_sl != SL_RST);
        assign w_wl_drv[i]  = (w_wl == WL_DRV);
        assign w_wl_rd[i]   = (w_wl == WL_RD);
        assign w_bl_pre[i]  = (w_bl == BL_PRE);
        assign w_col_set[i] = (w_bl == BL_SET) && w_sl_gnd;
        assign w_col_rst[i] = w_bl_gnd && (w_sl == SL_RST);
        assign w_col_gnd[i] = w_bl_gnd && w_sl_gnd;
    end

    assign w_col_sel = w_col_set | w_col_rst;

    always_comb begin
        w_row = '0;
        w_col = '0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            if (w_wl_drv[i])  w_row = IDX_W'(i);
            if (w_col_sel[i]) w_col = IDX_W'(i);
        end
    end

    assign w_pol = |w_col_set;

    // A write frame is any all-enabled drive with at least one row and one
    // column selected and every other column idle; it is legal only when
    // exactly one row and one column are selected.
    assign w_wr_frame = bus.ENABLE_WL && bus.ENABLE_SL && bus.ENABLE_BL
                        && (&(w_col_sel | w_col_gnd))
                        && (w_wl_drv != '0) && (w_col_sel != '0);
    assign w_wr_ok    = w_wr_frame && ($countones(w_wl_drv) == 1)
                        && ($countones(w_col_sel) == 1);
    assign w_wr_bad   = w_wr_frame && !w_wr_ok;
    assign w_wr_same  = w_wr_ok && (w_row == r_row) && (w_col == r_col)
                        && (w_pol == r_pol);

    assign w_rd_start  = !bus.ENABLE_WL && !bus.ENABLE_SL && !bus.ENABLE_BL
                         && (&w_bl_pre);
    assign w_sense     = bus.SAEN_CSA && bus.ENABLE_WL && bus.ENABLE_BL
                         && !bus.ENABLE_SL && bus.PRE;
    assign w_mac_start = (bus.CLK_EN_ADC != 2'b00) && bus.ENABLE_WL
                         && bus.ENABLE_BL && !bus.ENABLE_SL;
    assign w_rd_multi  = ($countones(r_mask) > 1);

    always_comb begin
        w_rd_or = '0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            if (r_mask[i]) w_rd_or = w_rd_or | r_cell[i];
        end
    end

    for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_col
        logic [ARRAY_SIZE-1:0] w_bits;
        logic [2:0]            w_code;
        for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_bit
            assign w_bits[i] = r_cell[i][j] & r_mask[i];
        end
        rram_col_popcount #(
            .ARRAY_SIZE (ARRAY_SIZE)
        ) u_popcount (
            .i_bits  (w_bits),
            .o_count (w_code)
        );
        assign w_adc0[j] = w_code[2];
        assign w_adc1[j] = w_code[1];
        assign w_adc2[j] = w_code[0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cell  <= '0;
            r_mask  <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_pol   <= 1'b0;
            r_csa   <= '0;
            r_adc0  <= '0;
            r_adc1  <= '0;
            r_adc2  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_bad) r_err <= 1'b1;
                    if (w_wr_ok) begin
                        r_state <= ST_WRITE;
                        r_cnt   <= CNT_W'(1);
                        r_row   <= w_row;
                        r_col   <= w_col;
                        r_pol   <= w_pol;
                    end else if (w_mac_start) begin
                        r_state <= ST_MAC_CONV;
                        r_cnt   <= MAC_LOAD;
                        r_mask  <= w_wl_drv;
                    end else if (w_rd_start) begin
                        r_state <= ST_READ_PRE;
                        r_mask  <= w_wl_rd;
                    end
                end
                ST_WRITE: begin
                    if (w_wr_bad) r_err <= 1'b1;
                    if (w_wr_same) begin
                        if (r_cnt >= WR_LAST) begin
                            r_cell[r_row][r_col] <= r_pol;
                            r_cnt   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_READ_PRE: begin
                    if (w_sense) begin
                        r_csa   <= w_rd_or;
                        if (w_rd_multi) r_err <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_MAC_CONV: begin
                    if (r_cnt == '0) begin
                        r_adc0  <= w_adc0;
                        r_adc1  <= w_adc1;
                        r_adc2  <= w_adc2;
                        r_valid <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.CSA       = r_csa;
    assign bus.ADC_OUT0  = r_adc0;
    assign bus.ADC_OUT1  = r_adc1;
    assign bus.ADC_OUT2  = r_adc2;
    assign bus.ADC_VALID = r_valid;
    assign bus.ERR_FLAG  = r_err;

endmodule

// File: tb/tb_rram_array_emulator.sv
// tb_rram_array_emulator
// Transaction-level model of the crossbar (cell array, expected CSA, MAC
// codes, valid pulse, error flag) compared against the DUT every falling edge,
// plus literal expectations for the directed scenarios.
module tb_rram_array_emulator;

    localparam int N   = 16;
    localparam int WPC = 2;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rram_array_emulator_if #(.ARRAY_SIZE(N)) bus ();

    rram_array_emulator #(
        .ARRAY_SIZE         (N),
        .WRITE_PULSE_CYCLES (WPC),
        .ADC_LATENCY        (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    bit           m_cell [N][N];
    logic [N-1:0] m_csa = '0;
    int           m_code [N];
    bit           m_valid = 1'b0;
    bit           m_err = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int n_valid_seen = 0;

    logic [N-1:0] e0, e1, e2;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual %h required %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int j = 0; j < N; j++) begin
            e0[j] = m_code[j][2];
            e1[j] = m_code[j][1];
            e2[j] = m_code[j][0];
        end
        chk("CSA", bus.CSA, m_csa);
        chk("ADC_OUT0", bus.ADC_OUT0, e0);
        chk("ADC_OUT1", bus.ADC_OUT1, e1);
        chk("ADC_OUT2", bus.ADC_OUT2, e2);
        chk("ADC_VALID", N'(bus.ADC_VALID), N'(m_valid));
        chk("ERR_FLAG", N'(bus.ERR_FLAG), N'(m_err));
        if (bus.ADC_VALID === 1'b1) n_valid_seen++;
    end

    task automatic reset_model();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) m_cell[r][c] = 1'b0;
            m_code[r] = 0;
        end
        m_csa   = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.ENABLE_WL  = 1'b0;
        bus.ENABLE_SL  = 1'b0;
        bus.ENABLE_BL  = 1'b0;
        bus.PRE        = 1'b0;
        bus.SAEN_CSA   = 1'b0;
        bus.CLK_EN_ADC = 2'b00;
        bus.IN0_WL = '1; bus.IN1_WL = '1;
        bus.IN0_BL = '1; bus.IN1_BL = '1;
        bus.IN0_SL = '1; bus.IN1_SL = '1;
    endtask

    task automatic set_wl(input int i, input logic [1:0] c);
        bus.IN0_WL[i] = c[1];
        bus.IN1_WL[i] = c[0];
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        reset_model();
        drive_idle();
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    // Pattern held for 'hold' edges, then grounded; commits iff hold >= WPC.
    task automatic do_write(input int row, input int col, input bit set, input int hold);
        drive_idle();
        bus.ENABLE_WL = 1'b1;
        bus.ENABLE_SL = 1'b1;
        bus.ENABLE_BL = 1'b1;
        set_wl(row, 2'b01);
        if (set) begin
            bus.IN0_BL[col] = 1'b0; bus.IN1_BL[col] = 1'b0;
        end else begin
            bus.IN0_SL[col] = 1'b0; bus.IN1_SL[col] = 1'b1;
        end
        repeat (hold) step();
        drive_idle();
        step();
        if (hold >= WPC) m_cell[row][col] = set;
    endtask

    task automatic do_bad_write(input logic [N-1:0] rows, input logic [N-1:0] cols);
        drive_idle();
        bus.ENABLE_WL = 1'b1;
        bus.ENABLE_SL = 1'b1;
        bus.ENABLE_BL = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (rows[i]) set_wl(i, 2'b01);
            if (cols[i]) begin bus.IN0_BL[i] = 1'b0; bus.IN1_BL[i] = 1'b0; end
        end
        step();
        m_err = 1'b1;
        step();
        drive_idle();
        step();
    endtask

    task automatic do_read(input logic [N-1:0] mask, input int waits);
        drive_idle();
        bus.IN0_BL = '0;
        bus.IN1_BL = '1;
        for (int i = 0; i < N; i++) set_wl(i, mask[i] ? 2'b00 : 2'b11);
        step();
        repeat (waits) begin
            bus.IN0_WL = N'($urandom);
            bus.IN1_WL = N'($urandom);
            step();
        end
        bus.SAEN_CSA  = 1'b1;
        bus.ENABLE_WL = 1'b1;
        bus.ENABLE_BL = 1'b1;
        bus.ENABLE_SL = 1'b0;
        bus.PRE       = 1'b1;
        step();
        m_csa = '0;
        for (int r = 0; r < N; r++)
            if (mask[r])
                for (int c = 0; c < N; c++) m_csa[c] = m_csa[c] | m_cell[r][c];
        if ($countones(mask) > 1) m_err = 1'b1;
        drive_idle();
        step();
    endtask

    task automatic mac_sample(input logic [N-1:0] mask);
        drive_idle();
        bus.ENABLE_WL  = 1'b1;
        bus.ENABLE_BL  = 1'b1;
        bus.ENABLE_SL  = 1'b0;
        bus.CLK_EN_ADC = 2'($urandom_range(1, 3));
        for (int i = 0; i < N; i++) set_wl(i, mask[i] ? 2'b01 : 2'b11);
        step();
    endtask

    task automatic mac_garbage();
        bus.ENABLE_WL  = 1'($urandom);
        bus.ENABLE_BL  = 1'($urandom);
        bus.ENABLE_SL  = 1'($urandom);
        bus.CLK_EN_ADC = 2'($urandom);
        bus.IN0_WL     = N'($urandom);
        bus.IN1_WL     = N'($urandom);
    endtask

    task automatic do_mac(input logic [N-1:0] mask);
        int cnt [N];
        mac_sample(mask);
        for (int j = 0; j < N; j++) begin
            cnt[j] = 0;
            for (int r = 0; r < N; r++) if (mask[r] && m_cell[r][j]) cnt[j]++;
            if (cnt[j] > 7) cnt[j] = 7;
        end
        repeat (LAT) begin
            mac_garbage();
            step();
        end
        for (int j = 0; j < N; j++) m_code[j] = cnt[j];
        m_valid = 1'b1;
        drive_idle();
        step();
        m_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 2000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] mask;
        int           vbase;
        rst = 1'b0;
        drive_idle();
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        chk("reset_csa", bus.CSA, 16'h0000);
        chk("reset_err", N'(bus.ERR_FLAG), 16'h0000);

        // SET (3,5) held two cycles, read row 3
        do_write(3, 5, 1'b1, 2);
        do_read(16'h0008, 0);
        chk("set_read", bus.CSA, 16'h0020);

        // aborted write: held one cycle only
        apply_reset();
        do_write(3, 5, 1'b1, 1);
        do_read(16'h0008, 1);
        chk("abort_read", bus.CSA, 16'h0000);
        chk("abort_err", N'(bus.ERR_FLAG), 16'h0000);

        // RESET of (3,5) leaves (3,6)
        apply_reset();
        do_write(3, 5, 1'b1, 2);
        do_write(3, 6, 1'b1, 2);
        do_write(3, 5, 1'b0, 2);
        do_read(16'h0008, 0);
        chk("reset_cell_read", bus.CSA, 16'h0040);

        // MAC: column 0 saturates at 7, column 1 gives 3
        apply_reset();
        for (int r = 0; r < 10; r++) do_write(r, 0, 1'b1, WPC);
        for (int r = 0; r < 3; r++) do_write(r, 1, 1'b1, WPC);
        vbase = n_valid_seen;
        do_mac('1);
        chk("mac_out0", bus.ADC_OUT0, 16'h0001);
        chk("mac_out1", bus.ADC_OUT1, 16'h0003);
        chk("mac_out2", bus.ADC_OUT2, 16'h0003);
        chk("mac_valid_pulses", N'(n_valid_seen - vbase), 16'h0001);

        // multi-row write: error, no cell change, sticky
        do_bad_write(16'h0006, 16'h0080);
        chk("err_set", N'(bus.ERR_FLAG), 16'h0001);
        do_read(16'h0002, 0);
        chk("err_row1", bus.CSA, 16'h0003);
        do_read(16'h0004, 0);
        chk("err_row2", bus.CSA, 16'h0003);
        do_mac(16'h0001);
        chk("err_sticky", N'(bus.ERR_FLAG), 16'h0001);

        // reset one cycle after MAC sample
        vbase = n_valid_seen;
        mac_sample('1);
        mac_garbage();
        step();
        rst = 1'b0;
        reset_model();
        drive_idle();
        step();
        step();
        rst = 1'b1;
        step();
        step();
        chk("rstmac_valid", N'(n_valid_seen - vbase), 16'h0000);
        chk("rstmac_out0", bus.ADC_OUT0, 16'h0000);
        chk("rstmac_out2", bus.ADC_OUT2, 16'h0000);
        chk("rstmac_err", N'(bus.ERR_FLAG), 16'h0000);
        do_read(16'h0001, 0);
        chk("rstmac_cells", bus.CSA, 16'h0000);
        do_mac('1);
        chk("rstmac_mac", bus.ADC_OUT2 | bus.ADC_OUT1 | bus.ADC_OUT0, 16'h0000);

        // randomized traffic against the model
        apply_reset();
        for (int k = 0; k < 300; k++) begin
            int op;
            int r;
            op = $urandom_range(0, 19);
            r  = $urandom_range(0, N - 1);
            if (op < 9) begin
                do_write(r, $urandom_range(0, N - 1), ($urandom_range(0, 3) != 0),
                         $urandom_range(1, 3));
            end else if (op < 14) begin
                mask = '0;
                case ($urandom_range(0, 9))
                    7:       mask = '0;
                    8, 9:    mask = N'($urandom);
                    default: mask[r] = 1'b1;
                endcase
                do_read(mask, $urandom_range(0, 2));
            end else if (op < 19) begin
                mask = ($urandom_range(0, 4) == 0) ? '1 : N'($urandom);
                do_mac(mask);
            end else begin
                mask = '0;
                mask[r] = 1'b1;
                mask[(r + 1 + $urandom_range(0, N - 2)) % N] = 1'b1;
                do_bad_write(mask, N'(1) << $urandom_range(0, N - 1));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rram_array_emulator.md
RRAM_ARRAY_EMULATOR -- requirements
Module: rram_array_emulator

Interface
REQ-001 Parameter ARRAY_SIZE, default 16, rows and columns of the square cell array.
REQ-002 Parameter WRITE_PULSE_CYCLES, default 2, consecutive cycles a write pattern SHALL be held before commit.
REQ-003 Parameter ADC_LATENCY, default 2, cycles from MAC sample to ADC_VALID.
REQ-004 Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ENABLE_WL / ENABLE_SL / ENABLE_BL  in  1 each  line-driver enables.
- PRE  in  1  precharge control.
- SAEN_CSA  in  1  sense-amp enable.
- CLK_EN_ADC  in  2  ADC clock enable; nonzero means active.
- IN0_WL / IN1_WL / IN0_BL / IN1_BL / IN0_SL / IN1_SL  in  ARRAY_SIZE each  per-line drive code, pair {IN0,IN1}.
- CSA  out  ARRAY_SIZE  sensed row data.
- ADC_OUT0 / ADC_OUT1 / ADC_OUT2  out  ARRAY_SIZE each  per-column 3-bit MAC code: bit2, bit1, bit0.
- ADC_VALID  out  1  one-cycle pulse when ADC_OUT* updates.
- ERR_FLAG  out  1  sticky illegal-pattern flag.

Function
REQ-005 Line codes: WL 01 = write/MAC drive, WL 00 = read select, WL 11 = ground; BL 00 = SET drive, BL 01 = precharge, BL 11 = ground; SL 01 = RESET drive, SL 11 = ground. Any other code on any line counts as ground.
REQ-006 FSM states: IDLE, WRITE, READ_PRE, MAC_CONV.
REQ-007 Write pattern: ENABLE_WL, ENABLE_SL and ENABLE_BL all 1, exactly one WL row at 01, and exactly one column at BL 00/SL 11 (SET) or at BL 11/SL 01 (RESET), with all other columns at 11/11.
REQ-008 IDLE->WRITE on a write pattern; the pulse counter SHALL be loaded with 1.
REQ-009 In WRITE, the counter SHALL increment while the pattern is unchanged. On reaching WRITE_PULSE_CYCLES, cell[row][col] SHALL be set to 1 (SET) or 0 (RESET) on that edge, and the FSM SHALL return to IDLE.
REQ-010 In WRITE, any change of row, column or polarity SHALL abort the write with no commit and return to IDLE.
REQ-011 A write pattern with more than one WL row or column selected SHALL set ERR_FLAG and SHALL not change any cell.
REQ-012 IDLE->READ_PRE when all enables are 0 and all BL are 01. The mask of WL rows at 00 SHALL be latched.
REQ-013 READ_PRE->IDLE on the first edge with SAEN_CSA=1, ENABLE_WL=1, ENABLE_BL=1, ENABLE_SL=0, PRE=1. On that edge CSA SHALL load cell[r] if exactly one row r was latched, or 0 if no rows were latched.
REQ-014 If more than one read row was latched, CSA SHALL load the bitwise OR of those rows and ERR_FLAG SHALL be set.
REQ-015 IDLE->MAC_CONV on CLK_EN_ADC!=0 with ENABLE_WL=1, ENABLE_BL=1, ENABLE_SL=0. The active-row mask (WL 01) SHALL be sampled on that edge.
REQ-016 MAC result per column j = popcount over active rows of cell[row][j], saturated to 7 (3 bits). ADC_OUT0[j]=bit2, ADC_OUT1[j]=bit1, ADC_OUT2[j]=bit0.
REQ-017 ADC_OUT* SHALL update, and ADC_VALID SHALL pulse, exactly ADC_LATENCY cycles after the sample edge. The FSM SHALL then return to IDLE.
REQ-018 Enable or WL changes during MAC_CONV SHALL be ignored.
REQ-019 CSA and ADC_OUT* SHALL hold their values between updates.
REQ-020 Where more than one IDLE exit condition holds on the same edge, priority SHALL be WRITE > MAC_CONV > READ_PRE.

Reset
REQ-021 On rst low, asynchronously: all cells 0, state IDLE, counters 0, CSA 0, ADC_OUT* 0, ADC_VALID 0, ERR_FLAG 0.
REQ-022 Reset during WRITE SHALL discard the pending commit.
REQ-023 Reset during MAC_CONV SHALL suppress ADC_VALID.

Structure
REQ-024 Shared package rram_pkg SHALL hold the line-code constants (WL_DRV, WL_RD, LINE_GND, BL_SET, BL_PRE, SL_RST) and the FSM state enum.
REQ-025 One sub-module, rram_col_popcount, SHALL compute the saturated 3-bit count for one column; it SHALL be instantiated ARRAY_SIZE times.

Verification
REQ-026 SET: WL row 3 = 01, column 5 SET, all enables 1, held 2 cycles, then read row 3 -> CSA = 16'h0020.
REQ-027 Aborted write: SET pattern on row 3, column 5 held 1 cycle, then grounded; read row 3 -> CSA = 0; ERR_FLAG = 0.
REQ-028 RESET: cells (3,5) and (3,6) SET, then RESET (3,5) -> read row 3 gives CSA = 16'h0040.
REQ-029 MAC: rows 0-9 SET in column 0 and rows 0-2 SET in column 1; MAC with all rows at 01 -> after 2 cycles column 0 code 7 (saturated), column 1 code 3; ADC_VALID pulses once.
REQ-030 Error: write pattern with rows 1 and 2 both at 01 -> ERR_FLAG = 1 and array unchanged; ERR_FLAG stays 1 until rst.
REQ-031 Reset mid-MAC: rst asserted 1 cycle after MAC sample -> no ADC_VALID; ADC_OUT* = 0; all cells 0.
